// File: rtl/binary_to_excess3_seq.sv
// Sequential binary to multi-digit excess-3 converter (shift-add-3, one bit per clock).
// Optional per-digit odd parity output EX_PAR when B2EX3_PARITY_EN is defined.
module binary_to_excess3_seq #(
  parameter int BIN_W = 8,
  parameter int NDIG  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BIN_W-1:0]      B_IN,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [4*NDIG-1:0]     EX_OUT,
  output logic                  ovf,
  output logic                  out_valid,
  input  logic                  out_ready
`ifdef B2EX3_PARITY_EN
  ,
  output logic [NDIG-1:0]       EX_PAR
`endif
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [31:0] MAX_DEC = 32'(10**NDIG - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]              r_state;
  logic [BIN_W-1:0]        r_shift;
  logic [4*NDIG-1:0]       r_bcd;
  logic [CNT_W-1:0]        r_cnt;
  logic [4*NDIG-1:0]       r_ex;
  logic                    r_ovf;

  logic [4*NDIG-1:0]       w_adj;
  logic [4*NDIG+BIN_W-1:0] w_cat_next;
  logic [4*NDIG-1:0]       w_ex3;
  logic                    w_ovf_in;

  assign w_ovf_in = ({{(32-BIN_W){1'b0}}, B_IN} > MAX_DEC);

  // Carries out of the top digit fall off the shift; ovf covers that case.
  assign w_cat_next = {w_adj, r_shift} << 1;

  genvar gi;
  generate
    for (gi = 0; gi < NDIG; gi++) begin : g_dig
      logic [3:0] w_d;
      assign w_d = r_bcd[4*gi +: 4];
      assign w_adj[4*gi +: 4] = (w_d >= 4'd5) ? (w_d + 4'd3) : w_d;
      assign w_ex3[4*gi +: 4] = w_cat_next[BIN_W + 4*gi +: 4] + 4'd3;
    end
  endgenerate

`ifdef B2EX3_PARITY_EN
  logic [NDIG-1:0] r_par;
  logic [NDIG-1:0] w_par;
  generate
    for (gi = 0; gi < NDIG; gi++) begin : g_par
      assign w_par[gi] = ~^w_ex3[4*gi +: 4];
    end
  endgenerate
  assign EX_PAR = r_par;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_par <= '0;
    end else if (r_state == S_CONV && r_cnt == CNT_W'(1)) begin
      r_par <= r_ovf ? '0 : w_par;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_ex    <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_shift <= B_IN;
            r_bcd   <= '0;
            r_cnt   <= CNT_W'(BIN_W);
            r_ovf   <= w_ovf_in;
            r_state <= S_CONV;
          end
        end
        S_CONV: begin
          r_shift <= w_cat_next[BIN_W-1:0];
          r_bcd   <= w_cat_next[4*NDIG+BIN_W-1:BIN_W];
          r_cnt   <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            // 0000 is not a legal excess-3 code, so it marks an overflowed result.
            r_ex    <= r_ovf ? '0 : w_ex3;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign EX_OUT    = r_ex;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_binary_to_excess3_seq.sv
// Self-checking bench for binary_to_excess3_seq: an 8-bit and a 10-bit instance (both 3 digits),
// table vectors, exhaustive 8-bit sweep, randomized 10-bit traffic, backpressure and reset abort.
module tb_binary_to_excess3_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic [7:0]  b8  = '0;
  logic        iv8 = 1'b0;
  logic        ir8;
  logic [11:0] ex8;
  logic        ov8;
  logic        vo8;
  logic        or8 = 1'b0;

  logic [9:0]  b10  = '0;
  logic        iv10 = 1'b0;
  logic        ir10;
  logic [11:0] ex10;
  logic        ov10;
  logic        vo10;
  logic        or10 = 1'b0;

`ifdef B2EX3_PARITY_EN
  logic [2:0]  par8;
  logic [2:0]  par10;
`endif

  always #5 clk = ~clk;

  binary_to_excess3_seq #(.BIN_W(8), .NDIG(3)) u_dut8 (
    .clk(clk), .rst(rst), .B_IN(b8), .in_valid(iv8), .in_ready(ir8),
    .EX_OUT(ex8), .ovf(ov8), .out_valid(vo8), .out_ready(or8)
`ifdef B2EX3_PARITY_EN
    , .EX_PAR(par8)
`endif
  );

  binary_to_excess3_seq #(.BIN_W(10), .NDIG(3)) u_dut10 (
    .clk(clk), .rst(rst), .B_IN(b10), .in_valid(iv10), .in_ready(ir10),
    .EX_OUT(ex10), .ovf(ov10), .out_valid(vo10), .out_ready(or10)
`ifdef B2EX3_PARITY_EN
    , .EX_PAR(par10)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit          w10;
    int          bin;
    logic [11:0] ex;
    logic        ov;
    logic [2:0]  par;
  } vec_t;

  localparam int NVEC = 10;
  vec_t vecs[NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: decimal digits by plain division, each digit + 3; zero on overflow.
  function automatic logic [11:0] model_ex(input int v);
    logic [11:0] r;
    int t;
    r = '0;
    if (v > 999) return r;
    t = v;
    for (int d = 0; d < 3; d++) begin
      r[4*d +: 4] = 4'(t % 10 + 3);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic model_ov(input int v);
    return (v > 999);
  endfunction

  function automatic logic [2:0] model_par(input logic [11:0] ex, input logic ov);
    logic [2:0] p;
    logic [3:0] nib;
    p = '0;
    if (ov) return p;
    for (int d = 0; d < 3; d++) begin
      nib  = ex[4*d +: 4];
      p[d] = ~(nib[0] ^ nib[1] ^ nib[2] ^ nib[3]);
    end
    return p;
  endfunction

  function automatic logic [11:0] cur_ex(input bit w10);
    return w10 ? ex10 : ex8;
  endfunction
  function automatic logic cur_ov(input bit w10);
    return w10 ? ov10 : ov8;
  endfunction
  function automatic logic cur_valid(input bit w10);
    return w10 ? vo10 : vo8;
  endfunction
  function automatic logic cur_ready(input bit w10);
    return w10 ? ir10 : ir8;
  endfunction

  task automatic set_in(input bit w10, input int v, input logic vld);
    if (w10) begin
      b10  = 10'(v);
      iv10 = vld;
    end else begin
      b8  = 8'(v);
      iv8 = vld;
    end
  endtask

  task automatic set_or(input bit w10, input logic r);
    if (w10) or10 = r;
    else     or8  = r;
  endtask

  // One full transaction; called #1 after a rising edge with the instance idle.
  task automatic do_conv(input string tag, input bit w10, input int v, input int hold,
                         input logic [11:0] exp_ex, input logic exp_ov, input logic [2:0] exp_par);
    int lat;
    int w;
    w = w10 ? 10 : 8;
    chk({tag, ":in_ready_idle"}, 32'(cur_ready(w10)), 32'd1);
    set_or(w10, 1'b0);
    set_in(w10, v, 1'b1);
    @(posedge clk); #1;
    set_in(w10, 0, 1'b0);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!cur_valid(w10) && lat < 40);
    chk({tag, ":latency"}, 32'(lat), 32'(w));
    chk({tag, ":ex_out"}, 32'(cur_ex(w10)), 32'(exp_ex));
    chk({tag, ":ovf"}, 32'(cur_ov(w10)), 32'(exp_ov));
    chk({tag, ":in_ready_done"}, 32'(cur_ready(w10)), 32'd0);
`ifdef B2EX3_PARITY_EN
    chk({tag, ":ex_par"}, 32'(w10 ? par10 : par8), 32'(exp_par));
`else
    if (exp_par !== 3'bxxx) begin end
`endif
    $display("[TB] %s B_IN=%0d EX_OUT=%h ovf=%0d lat=%0d hold=%0d", tag, v, cur_ex(w10),
             cur_ov(w10), lat, hold);
    for (int h = 0; h < hold; h++) begin
      // Offered operands while the result is pending must be ignored.
      set_in(w10, int'($urandom_range(0, 1023)), 1'b1);
      @(posedge clk); #1;
      chk({tag, ":hold_ex"}, 32'(cur_ex(w10)), 32'(exp_ex));
      chk({tag, ":hold_valid"}, 32'({cur_valid(w10), cur_ready(w10), cur_ov(w10)}),
          32'({1'b1, 1'b0, exp_ov}));
    end
    set_in(w10, 0, 1'b0);
    set_or(w10, 1'b1);
    @(posedge clk); #1;
    set_or(w10, 1'b0);
    chk({tag, ":release"}, 32'({cur_valid(w10), cur_ready(w10)}), 32'b01);
  endtask

  initial begin
    int v;
    bit seen;
    logic [11:0] e;

    vecs[0] = '{1'b0, 0,    12'h333, 1'b0, 3'b111};
    vecs[1] = '{1'b0, 255,  12'h588, 1'b0, 3'b100};
    vecs[2] = '{1'b0, 9,    12'h33C, 1'b0, 3'b111};
    vecs[3] = '{1'b0, 100,  12'h433, 1'b0, 3'b011};
    vecs[4] = '{1'b0, 99,   12'h3CC, 1'b0, 3'b111};
    vecs[5] = '{1'b0, 10,   12'h343, 1'b0, 3'b101};
    vecs[6] = '{1'b1, 999,  12'hCCC, 1'b0, 3'b111};
    vecs[7] = '{1'b1, 1000, 12'h000, 1'b1, 3'b000};
    vecs[8] = '{1'b1, 1023, 12'h000, 1'b1, 3'b000};
    vecs[9] = '{1'b1, 42,   12'h375, 1'b0, 3'b101};

    #2 rst = 1'b1;
    #1;
    chk("reset8", 32'({vo8, ir8, ov8, ex8}), 32'({1'b0, 1'b1, 1'b0, 12'h000}));
    chk("reset10", 32'({vo10, ir10, ov10, ex10}), 32'({1'b0, 1'b1, 1'b0, 12'h000}));
`ifdef B2EX3_PARITY_EN
    chk("reset_par", 32'({par8, par10}), 32'd0);
`endif
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      do_conv(vecs[i].w10 ? "vec10" : "vec8", vecs[i].w10, vecs[i].bin, 0,
              vecs[i].ex, vecs[i].ov, vecs[i].par);
    end

    do_conv("backpressure", 1'b0, 255, 20, 12'h588, 1'b0, 3'b100);
    do_conv("backpressure10", 1'b1, 1010, 5, 12'h000, 1'b1, 3'b000);

    // Reset part-way through converting 200 must abort without a result.
    set_in(1'b0, 200, 1'b1);
    @(posedge clk); #1;
    set_in(1'b0, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_reset", 32'({vo8, ir8, ov8, ex8}), 32'({1'b0, 1'b1, 1'b0, 12'h000}));
    @(posedge clk); #1;
    rst = 1'b0;
    or8  = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (vo8) seen = 1'b1;
    end
    or8 = 1'b0;
    chk("abort_no_output", 32'(seen), 32'd0);
    do_conv("after_abort", 1'b0, 42, 0, 12'h375, 1'b0, 3'b101);

    for (int i = 0; i < 256; i++) begin
      e = model_ex(i);
      do_conv("sweep8", 1'b0, i, 0, e, model_ov(i), model_par(e, model_ov(i)));
    end

    for (int i = 0; i < 150; i++) begin
      v = int'($urandom_range(0, 1023));
      e = model_ex(v);
      do_conv("rand10", 1'b1, v, int'($urandom_range(0, 3)), e, model_ov(v),
              model_par(e, model_ov(v)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
